// File: rtl/button_conditioner.sv
// button_conditioner: synchronises, debounces and auto-repeats the four game
// push-buttons. Each button yields a clean debounced level and a one-cycle
// move pulse: one on the press and, for repeat-enabled buttons, periodic
// pulses while the button stays held.
module button_conditioner #(
  parameter int               N_BTN         = 4,
  parameter int               DEBOUNCE_CYC  = 1_000_000,
  parameter int               REPEAT_DELAY  = 20_000_000,
  parameter int               REPEAT_PERIOD = 5_000_000,
  parameter logic [N_BTN-1:0] REPEAT_MASK   = 4'b0111,
  parameter int               CNT_W         = 25
) (
  input  logic             clk_50,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_raw,
  input  logic             enable,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_pulse
);

  localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0] RD_LAST  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RP_LAST  = CNT_W'(REPEAT_PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2,
    HELD   = 2'd3
  } rep_state_t;

  logic [N_BTN-1:0] sync_meta;
  logic [N_BTN-1:0] sync_q;

  // Two-flop synchroniser bringing the asynchronous key levels into clk_50.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would collapse the two stages into one.
  always_ff @(posedge clk_50) begin
    if (reset) begin
      sync_meta <= '0;
      sync_q    <= '0;
    end else begin
      sync_meta <= btn_raw;
      sync_q    <= sync_meta;
    end
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    logic [CNT_W-1:0] db_cnt;
    logic             level_q;
    logic             level_next;
    logic [CNT_W-1:0] rep_cnt;
    rep_state_t       state;
    logic             pulse_q;

    // Debounced level this edge will commit; the repeat FSM looks at it so
    // the press pulse coincides with the level rising and a release beats a
    // repeat pulse due in the same cycle.
    // NOTE: the default assignment first keeps this block free of latches.
    always_comb begin
      level_next = level_q;
      if ((sync_q[i] != level_q) && (db_cnt == DB_LAST)) begin
        level_next = sync_q[i];
      end
    end

    // Debounce counter: counts consecutive disagreeing cycles, any bounce
    // back to the current level restarts it.
    always_ff @(posedge clk_50) begin
      if (reset) begin
        db_cnt  <= '0;
        level_q <= 1'b0;
      end else if (sync_q[i] == level_q) begin
        db_cnt  <= '0;
      end else if (db_cnt == DB_LAST) begin
        db_cnt  <= '0;
        level_q <= sync_q[i];
      end else begin
        db_cnt  <= db_cnt + CNT_ONE;
      end
    end

    // Press / auto-repeat FSM with a registered pulse output; pausing
    // forces it idle so a button held across resume needs a fresh press.
    always_ff @(posedge clk_50) begin
      if (reset) begin
        state   <= IDLE;
        rep_cnt <= '0;
        pulse_q <= 1'b0;
      end else begin
        pulse_q <= 1'b0;
        if (!enable) begin
          state   <= IDLE;
          rep_cnt <= '0;
        end else begin
          case (state)
            IDLE: begin
              if (level_next && !level_q) begin
                pulse_q <= 1'b1;
                rep_cnt <= '0;
                state   <= REPEAT_MASK[i] ? DELAY : HELD;
              end
            end
            DELAY: begin
              if (!level_next) begin
                state <= IDLE;
              end else if (rep_cnt == RD_LAST) begin
                pulse_q <= 1'b1;
                rep_cnt <= '0;
                state   <= REPEAT;
              end else begin
                rep_cnt <= rep_cnt + CNT_ONE;
              end
            end
            REPEAT: begin
              if (!level_next) begin
                state <= IDLE;
              end else if (rep_cnt == RP_LAST) begin
                pulse_q <= 1'b1;
                rep_cnt <= '0;
              end else begin
                rep_cnt <= rep_cnt + CNT_ONE;
              end
            end
            HELD: begin
              if (!level_next) begin
                state <= IDLE;
              end
            end
            default: state <= IDLE;
          endcase
        end
      end
    end

    assign btn_level[i] = level_q;
    assign btn_pulse[i] = pulse_q;
  end

endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: directed scenarios plus a randomized soak, checked
// every cycle against a cycle-counting reference model of the button rules
// (run-length debounce, press-age arithmetic for repeat pulses).
module tb_button_conditioner;

  localparam int         DEB  = 4;
  localparam int         RD   = 10;
  localparam int         RP   = 3;
  localparam logic [3:0] MASK = 4'b0111;

  logic       clk_50;
  logic       reset;
  logic [3:0] btn_raw;
  logic       enable;
  logic [3:0] btn_level;
  logic [3:0] btn_pulse;

  button_conditioner #(
    .N_BTN        (4),
    .DEBOUNCE_CYC (DEB),
    .REPEAT_DELAY (RD),
    .REPEAT_PERIOD(RP),
    .REPEAT_MASK  (MASK),
    .CNT_W        (25)
  ) dut (
    .clk_50   (clk_50),
    .reset    (reset),
    .btn_raw  (btn_raw),
    .enable   (enable),
    .btn_level(btn_level),
    .btn_pulse(btn_pulse)
  );

  initial clk_50 = 1'b0;
  always #10 clk_50 = ~clk_50;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int t0       = 0;

  // Reference model state.
  logic [3:0] m_s1, m_s2, m_level, m_pulse;
  int         m_run   [4];
  bit         m_active[4];
  int         m_start [4];

  // Per-scenario observation log.
  int         pcount[4];
  int         pfirst[4];
  int         plast [4];
  int         lrise [4];
  int         lfall [4];
  logic [3:0] prev_lvl;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Advances the model across one clock edge using the inputs about to be sampled.
  task automatic model_step();
    logic [3:0] new_level;
    if (reset) begin
      m_s1 = '0; m_s2 = '0; m_level = '0; m_pulse = '0;
      for (int b = 0; b < 4; b++) begin
        m_run[b] = 0; m_active[b] = 0; m_start[b] = 0;
      end
    end else begin
      new_level = m_level;
      for (int b = 0; b < 4; b++) begin
        m_run[b] = (m_s2[b] != m_level[b]) ? m_run[b] + 1 : 0;
        if (m_run[b] == DEB) begin
          new_level[b] = m_s2[b];
          m_run[b]     = 0;
        end
      end
      m_s2 = m_s1;
      m_s1 = btn_raw;
      for (int b = 0; b < 4; b++) begin
        m_pulse[b] = 1'b0;
        if (!enable) begin
          m_active[b] = 0;
        end else if (new_level[b] && !m_level[b]) begin
          m_active[b] = 1;
          m_start[b]  = cyc + 1;
          m_pulse[b]  = 1'b1;
        end else if (!new_level[b]) begin
          m_active[b] = 0;
        end else if (m_active[b] && MASK[b]) begin
          int age;
          age = cyc + 1 - m_start[b];
          if (age >= RD && ((age - RD) % RP) == 0) m_pulse[b] = 1'b1;
        end
      end
      m_level = new_level;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk_50);
    #1;
    cyc++;
    for (int b = 0; b < 4; b++) begin
      if (btn_pulse[b] === 1'b1) begin
        pcount[b]++;
        if (pfirst[b] < 0) pfirst[b] = cyc;
        plast[b] = cyc;
      end
      if (btn_level[b] === 1'b1 && prev_lvl[b] === 1'b0) lrise[b] = cyc;
      if (btn_level[b] === 1'b0 && prev_lvl[b] === 1'b1) lfall[b] = cyc;
    end
    prev_lvl = btn_level;
    check("level_vs_model", {28'd0, btn_level}, {28'd0, m_level});
    check("pulse_vs_model", {28'd0, btn_pulse}, {28'd0, m_pulse});
  endtask

  task automatic run_to(input int rel);
    while (cyc < t0 + rel) tick();
  endtask

  task automatic new_scenario();
    t0 = cyc;
    for (int b = 0; b < 4; b++) begin
      pcount[b] = 0; pfirst[b] = -1; plast[b] = -1; lrise[b] = -1; lfall[b] = -1;
    end
  endtask

  initial begin
    reset    = 1'b1;
    enable   = 1'b1;
    btn_raw  = '0;
    prev_lvl = '0;
    m_s1 = '0; m_s2 = '0; m_level = '0; m_pulse = '0;
    for (int b = 0; b < 4; b++) begin
      m_run[b] = 0; m_active[b] = 0; m_start[b] = 0;
    end
    new_scenario();
    tick(); tick(); tick();
    check("reset_level", {28'd0, btn_level}, 32'd0);
    check("reset_pulse", {28'd0, btn_pulse}, 32'd0);
    reset = 1'b0;
    tick(); tick(); tick();

    // 1: clean press of bit 0 held 40 cycles.
    new_scenario();
    btn_raw[0] = 1'b1;
    run_to(40);
    btn_raw[0] = 1'b0;
    run_to(55);
    check("t1_level_rise", lrise[0] - t0, 6);
    check("t1_first_pulse", pfirst[0] - t0, 6);
    check("t1_last_pulse", plast[0] - t0, 43);
    check("t1_pulse_count", pcount[0], 11);
    check("t1_level_fall", lfall[0] - t0, 46);

    // 2: bounce on bit 1, then steady.
    new_scenario();
    btn_raw[1] = 1'b1;
    run_to(2);
    btn_raw[1] = 1'b0;
    run_to(4);
    btn_raw[1] = 1'b1;
    run_to(12);
    btn_raw[1] = 1'b0;
    run_to(25);
    check("t2_pulse_count", pcount[1], 1);
    check("t2_pulse_at", pfirst[1] - t0, 10);

    // 3: rotate held 50 cycles never repeats.
    new_scenario();
    btn_raw[3] = 1'b1;
    run_to(50);
    btn_raw[3] = 1'b0;
    run_to(60);
    check("t3_pulse_count", pcount[3], 1);
    check("t3_pulse_at", pfirst[3] - t0, 6);
    check("t3_level_fall", lfall[3] - t0, 56);

    // 4: press while paused, resume while held, then a fresh press.
    new_scenario();
    enable     = 1'b0;
    btn_raw[2] = 1'b1;
    run_to(10);
    check("t4_level_paused", {31'd0, btn_level[2]}, 32'd1);
    check("t4_no_pulse_paused", pcount[2], 0);
    run_to(12);
    enable = 1'b1;
    run_to(30);
    check("t4_no_pulse_resume", pcount[2], 0);
    btn_raw[2] = 1'b0;
    run_to(40);
    btn_raw[2] = 1'b1;
    run_to(48);
    btn_raw[2] = 1'b0;
    run_to(60);
    check("t4_repress_count", pcount[2], 1);
    check("t4_repress_at", pfirst[2] - t0, 46);

    // 5: simultaneous press of bits 0 and 1, reset mid-repeat.
    new_scenario();
    btn_raw[1:0] = 2'b11;
    run_to(21);
    check("t5_count_b0", pcount[0], 3);
    check("t5_count_b1", pcount[1], 3);
    check("t5_first_b1", pfirst[1] - t0, 6);
    check("t5_last_b0", plast[0] - t0, 19);
    check("t5_last_b1", plast[1] - t0, 19);
    reset = 1'b1;
    tick();
    check("t5_reset_pulse", {28'd0, btn_pulse}, 32'd0);
    check("t5_reset_level", {28'd0, btn_level}, 32'd0);
    tick();
    reset = 1'b0;
    run_to(35);
    btn_raw[1:0] = 2'b00;
    run_to(50);

    // 6: release lands on the cycle a repeat pulse is due.
    new_scenario();
    btn_raw[0] = 1'b1;
    run_to(19);
    btn_raw[0] = 1'b0;
    run_to(35);
    check("t6_pulse_count", pcount[0], 4);
    check("t6_last_pulse", plast[0] - t0, 22);
    check("t6_level_fall", lfall[0] - t0, 25);

    // Randomized soak: sticky random levels with occasional glitches,
    // pauses and resets, compared against the model every cycle.
    for (int i = 0; i < 1500; i++) begin
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(0, 29) == 0) btn_raw[b] = ~btn_raw[b];
      end
      if ($urandom_range(0, 149) == 0) enable = ~enable;
      reset = ($urandom_range(0, 399) == 0);
      tick();
    end
    reset   = 1'b0;
    enable  = 1'b1;
    btn_raw = '0;
    t0      = cyc;
    run_to(20);
    check("final_level", {28'd0, btn_level}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
